// File: rtl/jb_oran_stat_cnt_bank_pkg.sv
// Shared constants, counter-mode enum and register-map helpers for the O-RAN stats bank.
package jb_oran_stat_pkg;

  localparam int unsigned STAT_NUM_CNT_DEF  = 24;
  localparam int unsigned STAT_CNT_W_DEF    = 32;
  localparam int unsigned STAT_NUM_FLAG_DEF = 16;
  localparam int unsigned STAT_ADDR_W_DEF   = 7;

  typedef enum logic {
    CM_SAT  = 1'b0,
    CM_WRAP = 1'b1
  } cnt_mode_e;

  // Flags and overflow words sit directly after the counter shadows
  function automatic int unsigned stat_flag_ofs(input int unsigned num_cnt);
    return num_cnt;
  endfunction

  function automatic int unsigned stat_ovf_ofs(input int unsigned num_cnt);
    return num_cnt + 1;
  endfunction

  function automatic cnt_mode_e stat_mode(input int unsigned sat_mode);
    if (sat_mode != 0) return CM_SAT;
    return CM_WRAP;
  endfunction

endpackage

// File: rtl/jb_oran_stat_cnt_bank_if.sv
// Event, flag, snapshot and register-read signals between the O-RAN engines/regmap and the stats bank.
interface jb_oran_stat_cnt_bank_if #(
  parameter int unsigned NUM_CNT  = jb_oran_stat_pkg::STAT_NUM_CNT_DEF,
  parameter int unsigned CNT_W    = jb_oran_stat_pkg::STAT_CNT_W_DEF,
  parameter int unsigned NUM_FLAG = jb_oran_stat_pkg::STAT_NUM_FLAG_DEF,
  parameter int unsigned ADDR_W   = jb_oran_stat_pkg::STAT_ADDR_W_DEF
);
  logic [NUM_CNT-1:0]  evt_inc;
  logic [NUM_FLAG-1:0] flag_set;
  logic [NUM_FLAG-1:0] flag_mask;
  logic                snap_req;
  logic                clr_on_snap;
  logic                flag_w1c_en;
  logic [NUM_FLAG-1:0] flag_w1c_data;
  logic                rd_en;
  logic [ADDR_W-1:0]   rd_addr;
  logic                rd_vld;
  logic [CNT_W-1:0]    rd_data;
  logic                rd_err;
  logic [NUM_FLAG-1:0] flags;
  logic [NUM_CNT-1:0]  ovf;
  logic                irq;

  modport master (
    output evt_inc, flag_set, flag_mask, snap_req, clr_on_snap,
           flag_w1c_en, flag_w1c_data, rd_en, rd_addr,
    input  rd_vld, rd_data, rd_err, flags, ovf, irq
  );

  modport slave (
    input  evt_inc, flag_set, flag_mask, snap_req, clr_on_snap,
           flag_w1c_en, flag_w1c_data, rd_en, rd_addr,
    output rd_vld, rd_data, rd_err, flags, ovf, irq
  );
endinterface

// File: rtl/jb_oran_stat_cnt_bank_cnt.sv
// One live event counter with coherent shadow capture, sticky overflow and clear-on-snapshot.
module jb_oran_stat_cnt
  import jb_oran_stat_pkg::*;
#(
  parameter int unsigned CNT_W = STAT_CNT_W_DEF,
  parameter cnt_mode_e   MODE  = CM_SAT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_evt,
  input  logic             i_snap,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_shadow,
  output logic             o_ovf
);

  logic [CNT_W-1:0] r_live;
  logic [CNT_W-1:0] r_shadow;
  logic             r_ovf;
  logic [CNT_W-1:0] w_live_nxt;
  logic             w_ovf_nxt;
  logic             w_at_max;
  logic             w_hit_max;

  assign w_at_max  = &r_live;
  assign w_hit_max = i_evt & w_at_max;

  // A clearing snapshot restarts from this cycle's event so nothing is lost
  always_comb begin
    w_live_nxt = r_live;
    w_ovf_nxt  = r_ovf | w_hit_max;
    if (i_evt) begin
      if (!w_at_max)           w_live_nxt = r_live + CNT_W'(1);
      else if (MODE == CM_WRAP) w_live_nxt = '0;
    end
    if (i_snap && i_clr) begin
      w_live_nxt = CNT_W'(i_evt);
      w_ovf_nxt  = w_hit_max;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_live   <= '0;
      r_shadow <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_live <= w_live_nxt;
      r_ovf  <= w_ovf_nxt;
      if (i_snap) r_shadow <= r_live;
    end
  end

  assign o_shadow = r_shadow;
  assign o_ovf    = r_ovf;

endmodule

// File: rtl/jb_oran_stat_cnt_bank.sv
// Parametrised statistics bank: NUM_CNT snapshot counters, sticky flags with irq, and a 1-cycle read port.
module jb_oran_stat_cnt_bank
  import jb_oran_stat_pkg::*;
#(
  parameter int unsigned NUM_CNT  = STAT_NUM_CNT_DEF,
  parameter int unsigned CNT_W    = STAT_CNT_W_DEF,
  parameter int unsigned NUM_FLAG = STAT_NUM_FLAG_DEF,
  parameter int unsigned SAT_MODE = 1,
  parameter int unsigned ADDR_W   = STAT_ADDR_W_DEF
) (
  input logic                 clk,
  input logic                 rst_n,
  jb_oran_stat_cnt_bank_if.slave bus
);

  localparam int unsigned IDX_W         = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1;
  localparam int unsigned STAT_FLAG_OFS = stat_flag_ofs(NUM_CNT);
  localparam int unsigned STAT_OVF_OFS  = stat_ovf_ofs(NUM_CNT);
  localparam cnt_mode_e   MODE          = stat_mode(SAT_MODE);

  logic [CNT_W-1:0]         w_shadow [NUM_CNT];
  logic [NUM_CNT-1:0]       w_ovf;
  logic [CNT_W+NUM_CNT-1:0] w_ovf_ext;
  logic [NUM_FLAG-1:0]      r_flags;
  logic                     r_irq;
  logic                     r_rd_vld;
  logic [CNT_W-1:0]         r_rd_data;
  logic                     r_rd_err;
  logic [CNT_W-1:0]         w_rd_data;
  logic                     w_rd_err;

  for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
    jb_oran_stat_cnt #(
      .CNT_W (CNT_W),
      .MODE  (MODE)
    ) u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_evt    (bus.evt_inc[gi]),
      .i_snap   (bus.snap_req),
      .i_clr    (bus.clr_on_snap),
      .o_shadow (w_shadow[gi]),
      .o_ovf    (w_ovf[gi])
    );
  end

  assign w_ovf_ext = {{CNT_W{1'b0}}, w_ovf};

  // Set wins over a same-cycle write-1-to-clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_flags <= (r_flags & ~({NUM_FLAG{bus.flag_w1c_en}} & bus.flag_w1c_data)) | bus.flag_set;
      r_irq   <= |(r_flags & bus.flag_mask);
    end
  end

  always_comb begin
    w_rd_data = '0;
    w_rd_err  = 1'b0;
    if (bus.rd_addr < ADDR_W'(NUM_CNT))
      w_rd_data = w_shadow[IDX_W'(bus.rd_addr)];
    else if (bus.rd_addr == ADDR_W'(STAT_FLAG_OFS))
      w_rd_data = CNT_W'(r_flags);
    else if (bus.rd_addr == ADDR_W'(STAT_OVF_OFS))
      w_rd_data = w_ovf_ext[CNT_W-1:0];
    else
      w_rd_err = 1'b1;
  end

  // Read data holds between reads; the error bit only accompanies a valid beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_vld  <= 1'b0;
      r_rd_data <= '0;
      r_rd_err  <= 1'b0;
    end else begin
      r_rd_vld <= bus.rd_en;
      if (bus.rd_en) begin
        r_rd_data <= w_rd_data;
        r_rd_err  <= w_rd_err;
      end else begin
        r_rd_err  <= 1'b0;
      end
    end
  end

  assign bus.rd_vld  = r_rd_vld;
  assign bus.rd_data = r_rd_data;
  assign bus.rd_err  = r_rd_err;
  assign bus.flags   = r_flags;
  assign bus.ovf     = w_ovf;
  assign bus.irq     = r_irq;

endmodule

// File: tb/tb_jb_oran_stat_cnt_bank.sv
// Scoreboard bench: a saturating and a wrapping 8-bit bank driven in lockstep, reads checked on rd_vld.
module tb_jb_oran_stat_cnt_bank;

  localparam int unsigned NC = 24;
  localparam int unsigned CW = 8;
  localparam int unsigned NF = 8;
  localparam int unsigned AW = 7;

  typedef struct {
    int          cyc;
    logic [31:0] d_sat;
    logic        e_sat;
    logic [31:0] d_wrap;
    logic        e_wrap;
  } rd_exp_t;

  logic clk;
  logic rst_n;
  logic [NC-1:0] evt_inc;
  logic [NF-1:0] flag_set;
  logic [NF-1:0] flag_mask;
  logic          snap_req;
  logic          clr_on_snap;
  logic          flag_w1c_en;
  logic [NF-1:0] flag_w1c_data;
  logic          rd_en;
  logic [AW-1:0] rd_addr;

  int      cyc;
  int      n_chk;
  int      n_pass;
  rd_exp_t sb_q[$];

  jb_oran_stat_cnt_bank_if #(.NUM_CNT(NC), .CNT_W(CW), .NUM_FLAG(NF), .ADDR_W(AW)) b_sat ();
  jb_oran_stat_cnt_bank_if #(.NUM_CNT(NC), .CNT_W(CW), .NUM_FLAG(NF), .ADDR_W(AW)) b_wrap ();

  assign b_sat.evt_inc        = evt_inc;
  assign b_sat.flag_set       = flag_set;
  assign b_sat.flag_mask      = flag_mask;
  assign b_sat.snap_req       = snap_req;
  assign b_sat.clr_on_snap    = clr_on_snap;
  assign b_sat.flag_w1c_en    = flag_w1c_en;
  assign b_sat.flag_w1c_data  = flag_w1c_data;
  assign b_sat.rd_en          = rd_en;
  assign b_sat.rd_addr        = rd_addr;
  assign b_wrap.evt_inc       = evt_inc;
  assign b_wrap.flag_set      = flag_set;
  assign b_wrap.flag_mask     = flag_mask;
  assign b_wrap.snap_req      = snap_req;
  assign b_wrap.clr_on_snap   = clr_on_snap;
  assign b_wrap.flag_w1c_en   = flag_w1c_en;
  assign b_wrap.flag_w1c_data = flag_w1c_data;
  assign b_wrap.rd_en         = rd_en;
  assign b_wrap.rd_addr       = rd_addr;

  jb_oran_stat_cnt_bank #(
    .NUM_CNT(NC), .CNT_W(CW), .NUM_FLAG(NF), .SAT_MODE(1), .ADDR_W(AW)
  ) u_dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b_sat)
  );

  jb_oran_stat_cnt_bank #(
    .NUM_CNT(NC), .CNT_W(CW), .NUM_FLAG(NF), .SAT_MODE(0), .ADDR_W(AW)
  ) u_dut_wrap (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int addr, input logic [31:0] ds, input logic es,
                    input logic [31:0] dw, input logic ew);
    rd_en   = 1'b1;
    rd_addr = AW'(addr);
    sb_q.push_back('{cyc + 1, ds, es, dw, ew});
    tick();
  endtask

  task automatic rd_end();
    rd_en = 1'b0;
    tick();
  endtask

  // Pop one expectation per valid beat and compare both banks
  always @(negedge clk) begin
    rd_exp_t it;
    if (b_sat.rd_vld || b_wrap.rd_vld) begin
      if (sb_q.size() == 0) begin
        chk("rd_vld_spurious", 32'(b_sat.rd_vld | b_wrap.rd_vld), 32'd0);
      end else begin
        it = sb_q.pop_front();
        chk("rd_vld_cycle", 32'(cyc), 32'(it.cyc));
        chk("sat_rd_vld", 32'(b_sat.rd_vld), 32'd1);
        chk("wrap_rd_vld", 32'(b_wrap.rd_vld), 32'd1);
        chk("sat_rd_data", 32'(b_sat.rd_data), it.d_sat);
        chk("sat_rd_err", 32'(b_sat.rd_err), 32'(it.e_sat));
        chk("wrap_rd_data", 32'(b_wrap.rd_data), it.d_wrap);
        chk("wrap_rd_err", 32'(b_wrap.rd_err), 32'(it.e_wrap));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    evt_inc = '0; flag_set = '0; flag_mask = NF'(8'h04);
    snap_req = 1'b0; clr_on_snap = 1'b0;
    flag_w1c_en = 1'b0; flag_w1c_data = '0;
    rd_en = 1'b0; rd_addr = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    chk("rst_rd_vld", 32'(b_sat.rd_vld), 32'd0);
    chk("rst_rd_data", 32'(b_sat.rd_data), 32'd0);
    chk("rst_rd_err", 32'(b_sat.rd_err), 32'd0);
    chk("rst_flags", 32'(b_sat.flags), 32'd0);
    chk("rst_ovf_sat", 32'(b_sat.ovf), 32'd0);
    chk("rst_ovf_wrap", 32'(b_wrap.ovf), 32'd0);
    chk("rst_irq", 32'(b_sat.irq), 32'd0);
    tick();

    // Five events on counter 3, snapshot, read back
    evt_inc[3] = 1'b1;
    repeat (5) tick();
    evt_inc = '0;
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    rd(3, 32'd5, 1'b0, 32'd5, 1'b0);
    rd_end();
    @(negedge clk);
    chk("idle_rd_vld", 32'(b_sat.rd_vld), 32'd0);
    chk("idle_rd_err", 32'(b_sat.rd_err), 32'd0);
    chk("idle_rd_hold", 32'(b_sat.rd_data), 32'd5);
    tick();

    // 300 events on counter 0: saturate at 255 vs wrap to 44
    evt_inc[0] = 1'b1;
    repeat (300) tick();
    evt_inc = '0;
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    rd(0, 32'd255, 1'b0, 32'd44, 1'b0);
    rd(NC + 1, 32'h01, 1'b0, 32'h01, 1'b0);
    rd_end();
    chk("ovf_sat_after_300", 32'(b_sat.ovf), 32'h1);
    chk("ovf_wrap_after_300", 32'(b_wrap.ovf), 32'h1);

    // Clear-on-snap with a coincident event, then an immediate second snap
    evt_inc[5] = 1'b1;
    repeat (10) tick();
    snap_req = 1'b1; clr_on_snap = 1'b1;
    tick();
    evt_inc = '0; clr_on_snap = 1'b0;
    rd(5, 32'd10, 1'b0, 32'd10, 1'b0);
    snap_req = 1'b0;
    rd(5, 32'd1, 1'b0, 32'd1, 1'b0);
    rd(0, 32'd0, 1'b0, 32'd0, 1'b0);
    rd(NC + 1, 32'd0, 1'b0, 32'd0, 1'b0);
    rd(3, 32'd0, 1'b0, 32'd0, 1'b0);
    rd_end();
    chk("ovf_cleared", 32'(b_sat.ovf), 32'd0);

    // Distinct counts on 0..2, back-to-back reads plus out-of-range
    evt_inc[2:0] = 3'b111; tick();
    evt_inc[2:0] = 3'b110; tick();
    evt_inc[2:0] = 3'b100; tick();
    evt_inc = '0;
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    rd(0, 32'd1, 1'b0, 32'd1, 1'b0);
    rd(1, 32'd2, 1'b0, 32'd2, 1'b0);
    rd(2, 32'd3, 1'b0, 32'd3, 1'b0);
    rd(NC + 5, 32'd0, 1'b1, 32'd0, 1'b1);
    rd(NC, 32'd0, 1'b0, 32'd0, 1'b0);
    rd_end();

    // Sticky flag, masked irq with one-cycle lag, set beats clear
    flag_set[2] = 1'b1;
    tick();
    flag_set = '0;
    @(negedge clk);
    chk("flag2_set", 32'(b_sat.flags), 32'h04);
    chk("irq_lag", 32'(b_sat.irq), 32'd0);
    @(negedge clk);
    chk("irq_rise", 32'(b_sat.irq), 32'd1);
    tick();
    flag_set[2] = 1'b1; flag_w1c_en = 1'b1; flag_w1c_data = NF'(8'h04);
    tick();
    flag_set = '0; flag_w1c_en = 1'b0; flag_w1c_data = '0;
    @(negedge clk);
    chk("set_beats_w1c", 32'(b_sat.flags), 32'h04);
    chk("irq_held", 32'(b_sat.irq), 32'd1);
    tick();
    rd(NC, 32'h04, 1'b0, 32'h04, 1'b0);
    rd_end();
    flag_w1c_en = 1'b1; flag_w1c_data = NF'(8'h04);
    tick();
    flag_w1c_en = 1'b0; flag_w1c_data = '0;
    @(negedge clk);
    chk("w1c_clear", 32'(b_sat.flags), 32'd0);
    chk("irq_fall_lag", 32'(b_sat.irq), 32'd1);
    @(negedge clk);
    chk("irq_fall", 32'(b_sat.irq), 32'd0);
    tick();
    flag_set[5] = 1'b1;
    tick();
    flag_set = '0;
    @(negedge clk);
    chk("flag5_set", 32'(b_wrap.flags), 32'h20);
    @(negedge clk);
    chk("irq_masked", 32'(b_sat.irq), 32'd0);
    tick();
    rd(NC, 32'h20, 1'b0, 32'h20, 1'b0);
    rd_end();

    // Reset while counting with a read being requested
    evt_inc = '1;
    repeat (3) tick();
    rd_en = 1'b1; rd_addr = AW'(1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rd_vld", 32'(b_sat.rd_vld), 32'd0);
    chk("arst_rd_data", 32'(b_sat.rd_data), 32'd0);
    chk("arst_flags", 32'(b_sat.flags), 32'd0);
    chk("arst_ovf", 32'(b_wrap.ovf), 32'd0);
    chk("arst_irq", 32'(b_sat.irq), 32'd0);
    repeat (2) tick();
    rd_en = 1'b0; evt_inc = '0;
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    rd(0, 32'd0, 1'b0, 32'd0, 1'b0);
    rd(5, 32'd0, 1'b0, 32'd0, 1'b0);
    rd(NC, 32'd0, 1'b0, 32'd0, 1'b0);
    rd_end();
    repeat (2) tick();
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/jb_oran_stat_cnt_bank.md
Name: jb_oran_stat_cnt_bank

Overview:
Parametrised statistics bank for the O-RAN low-PHY datapath; next generation of the fixed per-signal error/count bundle.
- Holds NUM_CNT event counters of CNT_W bits, each selectable saturate or wrap, plus NUM_FLAG sticky error flags.
- A single snapshot strobe captures all counters coherently into shadow registers, with optional clear-on-snapshot.
- Sits between the UL/DL/PRACH O-RAN engines (event pulses) and the regmap, which reads shadows over a 1-cycle read port and clears flags write-1-to-clear.

Parameters:
NUM_CNT, 24, number of event counters (1..64)
CNT_W, 32, counter width in bits (8..32)
NUM_FLAG, 16, number of sticky error flags (1..CNT_W)
SAT_MODE, 1, 1 = counters saturate at all-ones; 0 = counters wrap to 0
ADDR_W, 7, read address width; must satisfy 2**ADDR_W >= NUM_CNT+2

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
evt_inc  input  NUM_CNT  per-counter increment pulse, one count per cycle high
flag_set  input  NUM_FLAG  per-flag set pulse
flag_mask  input  NUM_FLAG  interrupt enable per flag
snap_req  input  1  capture all live counters into shadows
clr_on_snap  input  1  sampled with snap_req; clears live counters on capture
flag_w1c_en  input  1  flag clear strobe
flag_w1c_data  input  NUM_FLAG  flags to clear where bit = 1
rd_en  input  1  read request
rd_addr  input  ADDR_W  read address
rd_vld  output  1  read data valid, 1 cycle after rd_en
rd_data  output  CNT_W  read data
rd_err  output  1  with rd_vld: address out of range
flags  output  NUM_FLAG  current sticky flags
ovf  output  NUM_CNT  sticky per-counter overflow/saturation indicator
irq  output  1  registered OR of (flags & flag_mask)

Behaviour:
- Reset (async assert, sync deassert outside block): all live counters, shadows, flags, ovf, rd_vld, rd_data, rd_err and irq are 0.
- Live counter, per cycle:
  - evt_inc[i] = 1 and counter < max: counter + 1.
  - At max (2**CNT_W - 1) with SAT_MODE = 1: hold max.
  - At max with SAT_MODE = 0: wrap to 0.
  - Either case at max sets ovf[i] (sticky).
- Snapshot: on snap_req, shadow[i] <= live[i] value before this cycle's increment, at the next edge, all counters in the same cycle.
- clr_on_snap = 1 with snap_req:
  - live[i] <= evt_inc[i] ? 1 : 0, so no event is lost.
  - ovf <= 0, except counters that overflow in that same cycle.
- snap_req without clr_on_snap: counting continues unaffected.
- Flags:
  - flags[j] <= (flags[j] & ~(flag_w1c_en & flag_w1c_data[j])) | flag_set[j].
  - Set and clear in the same cycle: set wins.
- irq <= |(flags & flag_mask), registered; 1-cycle lag after flags.
- Read port: rd_en in cycle N gives rd_vld = 1 in cycle N+1 only. Address map:
  - 0..NUM_CNT-1: shadow[addr].
  - NUM_CNT: flags, zero-extended to CNT_W.
  - NUM_CNT+1: ovf bits [CNT_W-1:0], zero-extended.
  - Any other address: rd_data = 0, rd_err = 1.
- Read vs snapshot: a read in the same cycle as snap_req returns the old shadow value.
- Back-to-back reads are supported, one per cycle; no backpressure.
- When rd_en = 0 next cycle, rd_data holds its last value and rd_err = 0.
- Reset asserted mid-operation: immediate clear of all state; a pending read is dropped (rd_vld = 0).

Decomposition:
- Package jb_oran_stat_pkg:
  - Address offset constants STAT_FLAG_OFS and STAT_OVF_OFS, as functions of NUM_CNT.
  - Counter-mode enum (SAT, WRAP).
  - Default widths.
- Sub-module jb_oran_stat_cnt: one live counter plus shadow plus ovf bit, with saturate/wrap and clear-on-snap. Instantiated NUM_CNT times in a generate loop.
- Flags, irq and read mux stay in the top level.

Test Plan:
- Reset, then 5 pulses on evt_inc[3], snap_req, read addr 3 -> rd_vld one cycle later, rd_data = 5, rd_err = 0.
- CNT_W = 8, SAT_MODE = 1, 300 pulses on evt_inc[0], snap, read 0 -> 255; read NUM_CNT+1 -> bit0 = 1. Repeat with SAT_MODE = 0 -> 44, ovf bit0 = 1.
- Live = 10 and evt_inc = 1 on the same cycle as snap_req with clr_on_snap = 1 -> shadow = 10, live = 1. Snap again immediately without events -> shadow = 1.
- flag_set[2] pulse -> flags = 0x0004. With flag_mask[2] = 1, irq rises 1 cycle later. w1c 0x0004 on the same cycle as a new flag_set[2] -> flag stays 1. w1c alone -> flags = 0, irq = 0 next cycle.
- Read address NUM_CNT+5 -> rd_data = 0, rd_err = 1. Back-to-back reads of addrs 0,1,2 -> three consecutive rd_vld cycles with matching shadows.
- Drop rst_n while counters are nonzero and a read is in flight -> all outputs 0 asynchronously, no rd_vld after release.
